// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: state codes, ALU op classes,
// PC/ALU-B select values, opcode constants and the packed strobe bundle.
package mc_pkg;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_MEMADR = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_EXEC   = 4'd6,
      ST_RWB    = 4'd7,
      ST_BRANCH = 4'd8,
      ST_JUMP   = 4'd9,
      ST_IEXEC  = 4'd10,
      ST_IWB    = 4'd11
   } state_e;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'd0,
      ALU_SUB  = 2'd1,
      ALU_FUNC = 2'd2,
      ALU_OR   = 2'd3
   } aluop_e;

   localparam logic [1:0] PC_ALU    = 2'd0;
   localparam logic [1:0] PC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;

   localparam logic [1:0] SRCB_REG    = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   typedef struct packed {
      logic       pc_wr;
      logic       pc_wr_cond;
      logic       ior_d;
      logic       mem_rd;
      logic       mem_wr;
      logic       ir_wr;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_wr;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      aluop_e     alu_op;
      logic [1:0] pc_src;
      logic       ext_op;
      logic       illegal;
   } ctrl_t;

   function automatic logic op_legal(input logic [5:0] op);
      logic ok;
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ORI: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mc_if.sv
// Instruction-field inputs and datapath control outputs of the multicycle controller.
interface mc_if;
   logic [5:0] op;
   logic [5:0] fun;
   logic       zero;
   logic       mem_ready;
   logic       PCWr, PCWrCond, IorD, MemRd, MenWr, IRWr, MentoReg, RegDst, RegWr, ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUop;
   logic [1:0] PCSrc;
   logic       Extop;
   logic       illegal;
   logic [3:0] state;

   modport slave (
      input  op, fun, zero, mem_ready,
      output PCWr, PCWrCond, IorD, MemRd, MenWr, IRWr, MentoReg, RegDst, RegWr, ALUSrcA,
             ALUSrcB, ALUop, PCSrc, Extop, illegal, state
   );

   modport master (
      output op, fun, zero, mem_ready,
      input  PCWr, PCWrCond, IorD, MemRd, MenWr, IRWr, MentoReg, RegDst, RegWr, ALUSrcA,
             ALUSrcB, ALUop, PCSrc, Extop, illegal, state
   );
endinterface

// File: rtl/mc_outdec.sv
// Moore output decode: state (plus op in DECODE/IEXEC) to datapath strobes.
// Only FETCH looks at the memory-ready qualifier, for PCWr and IRWr.
module mc_outdec
   import mc_pkg::*;
(
   input  state_e     state,
   input  logic [5:0] op,
   input  logic       ready,
   output ctrl_t      ctrl
);

   // Strobe decode; everything not set for a state stays 0.
   always_comb begin
      ctrl = '0;
      case (state)
         ST_FETCH: begin
            ctrl.mem_rd    = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALU_ADD;
            ctrl.pc_src    = PC_ALU;
            ctrl.ir_wr     = ready;
            ctrl.pc_wr     = ready;
         end
         ST_DECODE: begin
            ctrl.alu_src_b = SRCB_IMM_SH;
            ctrl.alu_op    = ALU_ADD;
            ctrl.illegal   = ~op_legal(op);
         end
         ST_MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_ADD;
            ctrl.ext_op    = 1'b1;
         end
         ST_MEMRD: begin
            ctrl.mem_rd = 1'b1;
            ctrl.ior_d  = 1'b1;
         end
         ST_MEMWB: begin
            ctrl.reg_wr     = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         ST_MEMWR: begin
            ctrl.mem_wr = 1'b1;
            ctrl.ior_d  = 1'b1;
         end
         ST_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALU_FUNC;
         end
         ST_RWB: begin
            ctrl.reg_wr  = 1'b1;
            ctrl.reg_dst = 1'b1;
         end
         ST_BRANCH: begin
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = SRCB_REG;
            ctrl.alu_op     = ALU_SUB;
            ctrl.pc_src     = PC_ALUOUT;
            ctrl.pc_wr_cond = 1'b1;
         end
         ST_JUMP: begin
            ctrl.pc_wr  = 1'b1;
            ctrl.pc_src = PC_JUMP;
         end
         ST_IEXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            // ori zero-extends and ORs; addi (and anything else) sign-extends and adds
            if (op == OP_ORI) begin
               ctrl.alu_op = ALU_OR;
               ctrl.ext_op = 1'b0;
            end else begin
               ctrl.alu_op = ALU_ADD;
               ctrl.ext_op = 1'b1;
            end
         end
         ST_IWB: begin
            ctrl.reg_wr = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM: next-state logic and state register.
// Build option MC_MEM_WAIT_EN: when defined, mem_ready stalls FETCH/MEMRD/MEMWR.
module multicycle_ctrl
   import mc_pkg::*;
(
   input logic clk,
   input logic rst,
   mc_if.slave bus
);

   state_e state_q;
   state_e state_d;
   logic   ready_s;
   ctrl_t  ctrl_s;
   logic   unused_s;

`ifdef MC_MEM_WAIT_EN
   assign ready_s = bus.mem_ready;
`else
   assign ready_s = 1'b1;
`endif

   // fun and zero are consumed by the datapath, not by this FSM
   assign unused_s = ^{bus.fun, bus.zero};

   // Next-state selection.
   always_comb begin
      state_d = ST_FETCH;
      case (state_q)
         ST_FETCH: begin
            if (ready_s) state_d = ST_DECODE;
            else         state_d = ST_FETCH;
         end
         ST_DECODE: begin
            case (bus.op)
               OP_RTYPE:        state_d = ST_EXEC;
               OP_LW, OP_SW:    state_d = ST_MEMADR;
               OP_BEQ, OP_BNE:  state_d = ST_BRANCH;
               OP_J:            state_d = ST_JUMP;
               OP_ADDI, OP_ORI: state_d = ST_IEXEC;
               default:         state_d = ST_FETCH;
            endcase
         end
         ST_MEMADR: begin
            if (bus.op == OP_SW) state_d = ST_MEMWR;
            else                 state_d = ST_MEMRD;
         end
         ST_MEMRD: begin
            if (ready_s) state_d = ST_MEMWB;
            else         state_d = ST_MEMRD;
         end
         ST_MEMWR: begin
            if (ready_s) state_d = ST_FETCH;
            else         state_d = ST_MEMWR;
         end
         ST_EXEC:  state_d = ST_RWB;
         ST_IEXEC: state_d = ST_IWB;
         ST_MEMWB, ST_RWB, ST_BRANCH, ST_JUMP, ST_IWB: state_d = ST_FETCH;
         default:  state_d = ST_FETCH;
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_FETCH;
      else     state_q <= state_d;
   end

   mc_outdec u_outdec (
      .state (state_q),
      .op    (bus.op),
      .ready (ready_s),
      .ctrl  (ctrl_s)
   );

   assign bus.PCWr     = ctrl_s.pc_wr;
   assign bus.PCWrCond = ctrl_s.pc_wr_cond;
   assign bus.IorD     = ctrl_s.ior_d;
   assign bus.MemRd    = ctrl_s.mem_rd;
   assign bus.MenWr    = ctrl_s.mem_wr;
   assign bus.IRWr     = ctrl_s.ir_wr;
   assign bus.MentoReg = ctrl_s.mem_to_reg;
   assign bus.RegDst   = ctrl_s.reg_dst;
   assign bus.RegWr    = ctrl_s.reg_wr;
   assign bus.ALUSrcA  = ctrl_s.alu_src_a;
   assign bus.ALUSrcB  = ctrl_s.alu_src_b;
   assign bus.ALUop    = ctrl_s.alu_op;
   assign bus.PCSrc    = ctrl_s.pc_src;
   assign bus.Extop    = ctrl_s.ext_op;
   // reset suppresses the illegal pulse even while sitting in DECODE
   assign bus.illegal  = ctrl_s.illegal & ~rst;
   assign bus.state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; covers both MC_MEM_WAIT_EN builds.
module tb_multicycle_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   mc_if bus_if ();

   multicycle_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   // strobe order: PCWr PCWrCond IorD MemRd MenWr IRWr MentoReg RegDst RegWr ALUSrcA
   localparam logic [9:0] S_FETCH  = 10'b1001010000;
   localparam logic [9:0] S_FSTALL = 10'b0001000000;
   localparam logic [9:0] S_NONE   = 10'b0000000000;
   localparam logic [9:0] S_SRCA   = 10'b0000000001;
   localparam logic [9:0] S_MEMRD  = 10'b0011000000;
   localparam logic [9:0] S_MEMWB  = 10'b0000001010;
   localparam logic [9:0] S_MEMWR  = 10'b0010100000;
   localparam logic [9:0] S_RWB    = 10'b0000000110;
   localparam logic [9:0] S_BRANCH = 10'b0100000001;
   localparam logic [9:0] S_JUMP   = 10'b1000000000;
   localparam logic [9:0] S_IWB    = 10'b0000000010;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [3:0] st, input logic [9:0] stb,
                          input logic [1:0] srcb, input logic [1:0] aop, input logic [1:0] pcs,
                          input logic ext, input logic ill);
      logic [21:0] obs;
      logic [21:0] exp;
      obs = {bus_if.state, bus_if.PCWr, bus_if.PCWrCond, bus_if.IorD, bus_if.MemRd,
             bus_if.MenWr, bus_if.IRWr, bus_if.MentoReg, bus_if.RegDst, bus_if.RegWr,
             bus_if.ALUSrcA, bus_if.ALUSrcB, bus_if.ALUop, bus_if.PCSrc, bus_if.Extop,
             bus_if.illegal};
      exp = {st, stb, srcb, aop, pcs, ext, ill};
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_fetch(input string tag);
      chk_out(tag, 4'd0, S_FETCH, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0);
   endtask

   task automatic chk_decode(input string tag, input logic ill);
      chk_out(tag, 4'd1, S_NONE, 2'd3, 2'd0, 2'd0, 1'b0, ill);
   endtask

   initial begin
      bus_if.op  = 6'b111111;
      bus_if.fun = 6'b100000;
      bus_if.zero = 1'b0;
`ifdef MC_MEM_WAIT_EN
      bus_if.mem_ready = 1'b1;
`else
      // memory handshake is ignored in this build, so hold it low throughout
      bus_if.mem_ready = 1'b0;
`endif
      rst = 1'b1;
      tick();
      tick();
      chk_fetch("reset_fetch");
      rst = 1'b0;

      // lw: 0,1,2,3,4,0
      bus_if.op = 6'b100011;
      chk_fetch("lw_fetch");
      tick(); chk_decode("lw_decode", 1'b0);
      tick(); chk_out("lw_memadr", 4'd2, S_SRCA, 2'd2, 2'd0, 2'd0, 1'b1, 1'b0);
      tick(); chk_out("lw_memrd", 4'd3, S_MEMRD, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
      tick(); chk_out("lw_memwb", 4'd4, S_MEMWB, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
      tick(); chk_fetch("lw_done");

      // sw
      bus_if.op = 6'b101011;
      tick(); chk_decode("sw_decode", 1'b0);
      tick(); chk_out("sw_memadr", 4'd2, S_SRCA, 2'd2, 2'd0, 2'd0, 1'b1, 1'b0);
`ifdef MC_MEM_WAIT_EN
      bus_if.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); chk_out("sw_memwr_wait", 4'd5, S_MEMWR, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
      end
      bus_if.mem_ready = 1'b1;
`endif
      tick(); chk_out("sw_memwr", 4'd5, S_MEMWR, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
      tick(); chk_fetch("sw_done");

      // R-type
      bus_if.op = 6'b000000;
      tick(); chk_decode("r_decode", 1'b0);
      tick(); chk_out("r_exec", 4'd6, S_SRCA, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0);
      tick(); chk_out("r_rwb", 4'd7, S_RWB, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
      tick(); chk_fetch("r_done");

      // beq and bne, both with zero=1
      bus_if.zero = 1'b1;
      bus_if.op = 6'b000100;
      tick(); chk_decode("beq_decode", 1'b0);
      tick(); chk_out("beq_branch", 4'd8, S_BRANCH, 2'd0, 2'd1, 2'd1, 1'b0, 1'b0);
      tick(); chk_fetch("beq_done");
      bus_if.op = 6'b000101;
      tick(); chk_decode("bne_decode", 1'b0);
      tick(); chk_out("bne_branch", 4'd8, S_BRANCH, 2'd0, 2'd1, 2'd1, 1'b0, 1'b0);
      tick(); chk_fetch("bne_done");
      bus_if.zero = 1'b0;

      // j
      bus_if.op = 6'b000010;
      tick(); chk_decode("j_decode", 1'b0);
      tick(); chk_out("j_jump", 4'd9, S_JUMP, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0);
      tick(); chk_fetch("j_done");

      // addi then ori
      bus_if.op = 6'b001000;
      tick(); chk_decode("addi_decode", 1'b0);
      tick(); chk_out("addi_iexec", 4'd10, S_SRCA, 2'd2, 2'd0, 2'd0, 1'b1, 1'b0);
      tick(); chk_out("addi_iwb", 4'd11, S_IWB, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
      tick(); chk_fetch("addi_done");
      bus_if.op = 6'b001101;
      tick(); chk_decode("ori_decode", 1'b0);
      tick(); chk_out("ori_iexec", 4'd10, S_SRCA, 2'd2, 2'd3, 2'd0, 1'b0, 1'b0);
      tick(); chk_out("ori_iwb", 4'd11, S_IWB, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
      tick(); chk_fetch("ori_done");

      // unsupported opcode: one-cycle illegal pulse, straight back to FETCH
      bus_if.op = 6'b111111;
      tick(); chk_decode("ill_decode", 1'b1);
      tick(); chk_fetch("ill_fetch");

      // reset while in DECODE with illegal op masks the pulse
      tick(); chk_decode("ill_decode2", 1'b1);
      rst = 1'b1;
      #1;
      chk_decode("ill_masked_by_rst", 1'b0);
      tick(); chk_fetch("ill_rst_fetch");
      rst = 1'b0;

`ifdef MC_MEM_WAIT_EN
      // FETCH stalls without mem_ready
      bus_if.mem_ready = 1'b0;
      chk_out("fetch_stall", 4'd0, S_FSTALL, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0);
      tick(); chk_out("fetch_stall2", 4'd0, S_FSTALL, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0);
      bus_if.mem_ready = 1'b1;
`endif

      // reset in MEMWR abandons the store
      bus_if.op = 6'b101011;
      tick(); chk_decode("swr_decode", 1'b0);
      tick(); chk_out("swr_memadr", 4'd2, S_SRCA, 2'd2, 2'd0, 2'd0, 1'b1, 1'b0);
      tick(); chk_out("swr_memwr", 4'd5, S_MEMWR, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
      rst = 1'b1;
      tick(); chk_fetch("swr_reset");
      rst = 1'b0;
      bus_if.op = 6'b000010;
      tick(); chk_decode("swr_restart", 1'b0);
      tick(); chk_out("swr_jump", 4'd9, S_JUMP, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0);
      tick(); chk_fetch("swr_done");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 clk  input  1  Rising-edge system clock; the only clock.
REQ-002 rst  input  1  Reset, synchronous, active-high.
REQ-003 op  input  6  Opcode field from the instruction register.
REQ-004 fun  input  6  Function field from the instruction register; informational only, R-type ALU decode is downstream.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  Memory handshake: the access completes in the cycle this is high.
REQ-007 PCWr, PCWrCond, IorD, MemRd, MenWr, IRWr, MentoReg, RegDst, RegWr, ALUSrcA  output  1 each  Datapath strobes and selects.
REQ-008 ALUSrcB  output  2  ALU B select: 0 reg, 1 const 4, 2 sign-extended imm, 3 imm<<2.
REQ-009 ALUop  output  2  ALU op class: ADD, SUB, FUNC, OR.
REQ-010 PCSrc  output  2  PC source: 0 ALU result, 1 ALUOut, 2 jump target.
REQ-011 Extop  output  1  1 = sign-extend, 0 = zero-extend.
REQ-012 illegal  output  1  One-cycle pulse when an unsupported opcode is decoded.
REQ-013 state  output  4  Current state, for debug.

Function
REQ-014 Moore FSM; all outputs are decoded from the state register only, except PCWr and IRWr in FETCH (REQ-016).
REQ-015 States and codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11; codes 12-15 go to FETCH on the next edge.
REQ-016 FETCH: MemRd=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUop=ADD, PCSrc=0; IRWr=PCWr=mem_ready; advances to DECODE only when mem_ready=1.
REQ-017 DECODE: ALUSrcA=0, ALUSrcB=3, ALUop=ADD. Next state by op: 000000->EXEC, 100011/101011->MEMADR, 000100/000101->BRANCH, 000010->JUMP, 001000/001101->IEXEC, any other->FETCH with illegal=1 for that cycle.
REQ-018 MEMADR: ALUSrcA=1, ALUSrcB=2, ALUop=ADD, Extop=1; next is MEMRD for lw, MEMWR for sw.
REQ-019 MEMRD: MemRd=1, IorD=1; advances to MEMWB when mem_ready=1.
REQ-020 MEMWB: RegWr=1, MentoReg=1, RegDst=0; next is FETCH.
REQ-021 MEMWR: MenWr=1, IorD=1; advances to FETCH when mem_ready=1; MenWr is held high until then.
REQ-022 EXEC: ALUSrcA=1, ALUSrcB=0, ALUop=FUNC, then RWB. RWB: RegWr=1, RegDst=1, MentoReg=0, then FETCH.
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=0, ALUop=SUB, PCSrc=1, PCWrCond=1. The branch is taken when zero=1 for beq (000100) or zero=0 for bne (000101). The taken condition is combined downstream with op[0]. Next state is FETCH.
REQ-024 JUMP: PCWr=1, PCSrc=2; next is FETCH.
REQ-025 IEXEC: ALUSrcA=1, ALUSrcB=2; ALUop=ADD with Extop=1 for addi, ALUop=OR with Extop=0 for ori; next is IWB. IWB: RegWr=1, RegDst=0, MentoReg=0; next is FETCH.
REQ-026 Every strobe not listed for a state is 0 in that state; selects are 0 unless listed.
REQ-027 Cycles per instruction with zero wait: lw 5, sw 4, R/addi/ori 4, beq/bne 3, j 3.

Reset
REQ-028 While rst=1 at a clock edge, state<=FETCH, and illegal is forced to 0 regardless of the current state.
REQ-029 Asserting rst mid-instruction (e.g. in MEMWR) abandons the instruction; no strobe from the abandoned state remains asserted after the reset edge.

Configuration
REQ-030 Macro MC_MEM_WAIT_EN.
- When defined: mem_ready gates the FETCH, MEMRD and MEMWR transitions as stated above.
- When undefined: mem_ready is ignored and treated as 1, so each memory state lasts exactly one cycle.

Structure
REQ-031 Package mc_pkg holds the state encoding, the ALUop encoding (ADD=0, SUB=1, FUNC=2, OR=3), the PCSrc/ALUSrcB encodings and the opcode constants.
REQ-032 Output decode lives in sub-module mc_outdec (state + op -> strobes); next-state logic and the register stay in multicycle_ctrl.

Verification
REQ-033 rst=1 for 2 cycles, then op=100011, mem_ready=1 -> states 0,1,2,3,4,0; RegWr=1 only in state 4; MentoReg=1 there.
REQ-034 op=101011, mem_ready low for 3 cycles in MEMWR (MC_MEM_WAIT_EN defined) -> MenWr=1 held for 4 cycles, then state=0.
REQ-035 op=000100 with zero=1 -> BRANCH with PCWrCond=1, PCSrc=1, ALUop=SUB; op=000101 with zero=1 -> same strobes, next state=0.
REQ-036 op=111111 -> DECODE then FETCH, illegal=1 for exactly one cycle, no RegWr/MenWr asserted.
REQ-037 rst asserted in MEMWR -> state=0 and MenWr=0 after the edge; the FETCH sequence restarts.
REQ-038 Build without MC_MEM_WAIT_EN, mem_ready=0 held -> lw still completes in 5 cycles.
